// File: rtl/usb_rx_pkt_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : usb_rx_pkt_ctrl_if
//  Description : Signal bundle for usb_rx_pkt_ctrl. It groups the receiver
//                FIFO read side, the forwarded byte stream and the
//                per-packet status.
//                slave  - view of the packet controller
//                master - view of the environment (receiver FIFO + consumer)
//  Ports       : none (signal container only)
//  Revision    : 1.0 - initial release
// ============================================================================
interface usb_rx_pkt_ctrl_if;
    // receiver side
    logic       rcving;
    logic       r_error;
    logic       empty;
    logic       full;
    logic [7:0] r_data;
    logic       r_enable;
    // forwarded stream
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_first;
    // packet status
    logic       pkt_done;
    logic [6:0] pkt_len;
    logic       pkt_err;
    logic       pid_err;
    logic       busy;

    modport slave (
        input  rcving, r_error, empty, full, r_data, out_ready,
        output r_enable, out_data, out_valid, out_first,
               pkt_done, pkt_len, pkt_err, pid_err, busy
    );

    modport master (
        output rcving, r_error, empty, full, r_data, out_ready,
        input  r_enable, out_data, out_valid, out_first,
               pkt_done, pkt_len, pkt_err, pid_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/usb_rx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : usb_rx_pkt_ctrl
//  Description : Packet-level read sequencer behind the USB receiver FIFO.
//                Pops bytes, validates the PID byte, forwards payload on a
//                valid/ready stream and reports a one-cycle packet-complete
//                pulse with length and error flags.
//  Ports       : clk    - system clock, rising edge
//                n_rst  - asynchronous active-low reset
//                bus    - usb_rx_pkt_ctrl_if.slave
//                         in : rcving, r_error, empty, full, r_data, out_ready
//                         out: r_enable (combinational), out_data, out_valid,
//                              out_first, pkt_done, pkt_len, pkt_err,
//                              pid_err, busy (all registered)
//  Parameters  : MAX_LEN - max bytes per packet including PID (1..127)
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_rx_pkt_ctrl #(
    parameter int MAX_LEN = 64
) (
    input  wire logic         clk,
    input  wire logic         n_rst,
    usb_rx_pkt_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [6:0] MAX_LEN_C = 7'(MAX_LEN);

    state_t     state_q;
    logic [6:0] count_q;
    logic       err_s_q;
    logic       pid_s_q;
    logic [7:0] out_data_q;
    logic       out_valid_q;
    logic       out_first_q;
    logic       pkt_done_q;
    logic [6:0] pkt_len_q;
    logic       pkt_err_q;
    logic       pid_err_q;
    logic       busy_q;

    logic can_take;
    logic accept;
    logic first_byte;
    logic pid_ok;
    logic pop;
    logic load;
    logic eop;
    logic to_done;

    // Output register can take a new byte if it is free or being drained now.
    assign can_take   = !out_valid_q || bus.out_ready;
    assign accept     = out_valid_q && bus.out_ready;
    assign first_byte = (count_q == 7'd0);
    assign pid_ok     = (bus.r_data[3:0] == ~bus.r_data[7:4]);

    // FLUSH drains regardless of the output stage; ACTIVE pops only when the
    // popped byte has somewhere to go.
    assign pop = (((state_q == ACTIVE) && can_take) || (state_q == FLUSH))
                 && !bus.empty;

    // A popped byte is forwarded unless it is a bad PID, beyond MAX_LEN, or
    // popped in the same cycle the receiver flags an error.
    assign load = (state_q == ACTIVE) && pop && !bus.r_error
                  && (first_byte ? pid_ok : (count_q != MAX_LEN_C));

    // End of packet: receiver finished, FIFO drained, output stage clear.
    // In ACTIVE this implies no pop (FIFO is empty).
    assign eop     = !bus.rcving && bus.empty && can_take;
    assign to_done = eop && (((state_q == ACTIVE) && !bus.r_error)
                             || (state_q == FLUSH));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            count_q     <= 7'd0;
            err_s_q     <= 1'b0;
            pid_s_q     <= 1'b0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            pkt_done_q  <= 1'b0;
            pkt_len_q   <= 7'd0;
            pkt_err_q   <= 1'b0;
            pid_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            pkt_done_q <= 1'b0;

            // Output stage: a load in the same cycle as an accept gives a
            // back-to-back transfer; the stage is otherwise held until taken.
            if (load) begin
                out_data_q  <= bus.r_data;
                out_valid_q <= 1'b1;
                out_first_q <= first_byte;
            end else if (accept) begin
                out_valid_q <= 1'b0;
                out_first_q <= 1'b0;
            end

            // Status is latched on the edge that enters DONE so it lines up
            // with the pkt_done pulse.
            if (to_done) begin
                pkt_done_q <= 1'b1;
                pkt_len_q  <= count_q;
                pkt_err_q  <= err_s_q || (count_q == 7'd0);
                pid_err_q  <= pid_s_q;
            end

            case (state_q)
                IDLE: begin
                    if (bus.rcving || !bus.empty) begin
                        state_q <= ACTIVE;
                        busy_q  <= 1'b1;
                        count_q <= 7'd0;
                        err_s_q <= 1'b0;
                        pid_s_q <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (bus.full && bus.rcving) begin
                        err_s_q <= 1'b1;
                    end
                    if (bus.r_error) begin
                        err_s_q <= 1'b1;
                        state_q <= FLUSH;
                    end else if (pop) begin
                        if (load) begin
                            count_q <= count_q + 7'd1;
                        end else if (first_byte) begin
                            pid_s_q <= 1'b1;
                            state_q <= FLUSH;
                        end else begin
                            err_s_q <= 1'b1;
                            state_q <= FLUSH;
                        end
                    end else if (to_done) begin
                        state_q <= DONE;
                    end
                end
                FLUSH: begin
                    if (to_done) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.r_enable  = pop;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_first = out_first_q;
    assign bus.pkt_done  = pkt_done_q;
    assign bus.pkt_len   = pkt_len_q;
    assign bus.pkt_err   = pkt_err_q;
    assign bus.pid_err   = pid_err_q;
    assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_rx_pkt_ctrl
//  Description : Directed self-checking bench for usb_rx_pkt_ctrl. Two
//                instances: dut_a (MAX_LEN=64) for most scenarios, dut_b
//                (MAX_LEN=4) for the overlength case. Each has a queue
//                modelling the first-word-fall-through receiver FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_rx_pkt_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       n_rst;
    logic       use_b;
    logic       rcving, r_error, full, out_ready;
    logic       a_empty, b_empty;
    logic [7:0] a_data, b_data;

    usb_rx_pkt_ctrl_if ifa ();
    usb_rx_pkt_ctrl_if ifb ();

    usb_rx_pkt_ctrl #(.MAX_LEN(64)) dut_a (.clk(clk), .n_rst(n_rst), .bus(ifa.slave));
    usb_rx_pkt_ctrl #(.MAX_LEN(4))  dut_b (.clk(clk), .n_rst(n_rst), .bus(ifb.slave));

    assign ifa.rcving    = rcving  & ~use_b;
    assign ifa.r_error   = r_error & ~use_b;
    assign ifa.full      = full    & ~use_b;
    assign ifa.out_ready = out_ready;
    assign ifa.empty     = a_empty;
    assign ifa.r_data    = a_data;
    assign ifb.rcving    = rcving  & use_b;
    assign ifb.r_error   = r_error & use_b;
    assign ifb.full      = full    & use_b;
    assign ifb.out_ready = out_ready;
    assign ifb.empty     = b_empty;
    assign ifb.r_data    = b_data;

    // View of the instance currently under test
    logic       m_valid, m_first, m_done, m_err, m_pid, m_ren, m_busy;
    logic [7:0] m_data;
    logic [6:0] m_len;
    assign m_valid = use_b ? ifb.out_valid : ifa.out_valid;
    assign m_first = use_b ? ifb.out_first : ifa.out_first;
    assign m_done  = use_b ? ifb.pkt_done  : ifa.pkt_done;
    assign m_err   = use_b ? ifb.pkt_err   : ifa.pkt_err;
    assign m_pid   = use_b ? ifb.pid_err   : ifa.pid_err;
    assign m_ren   = use_b ? ifb.r_enable  : ifa.r_enable;
    assign m_busy  = use_b ? ifb.busy      : ifa.busy;
    assign m_data  = use_b ? ifb.out_data  : ifa.out_data;
    assign m_len   = use_b ? ifb.pkt_len   : ifa.pkt_len;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] acc_data[$];
    logic       acc_first[$];
    int         acc_cyc[$];
    int         cyc, pops, done_cnt;
    logic [6:0] last_len;
    logic       last_err, last_pid;
    int         n_cmp, n_bad;

    function automatic void refresh();
        a_empty = (qa.size() == 0);
        a_data  = (qa.size() != 0) ? qa[0] : 8'h00;
        b_empty = (qb.size() == 0);
        b_data  = (qb.size() != 0) ? qb[0] : 8'h00;
    endfunction

    task automatic push(input logic [7:0] b);
        if (use_b) qb.push_back(b);
        else       qa.push_back(b);
        refresh();
    endtask

    task automatic clear_rec();
        acc_data.delete();
        acc_first.delete();
        acc_cyc.delete();
        pops     = 0;
        done_cnt = 0;
    endtask

    // One clock: observe handshakes/pops on the edge (pre-update values),
    // then advance the FIFO model and record status 1 time unit later.
    task automatic step();
        logic pa, pb;
        @(posedge clk);
        pa = ifa.r_enable;
        pb = ifb.r_enable;
        if (m_valid && out_ready) begin
            acc_data.push_back(m_data);
            acc_first.push_back(m_first);
            acc_cyc.push_back(cyc);
        end
        if (m_ren) pops++;
        #1;
        cyc++;
        if (pa && qa.size() != 0) void'(qa.pop_front());
        if (pb && qb.size() != 0) void'(qb.pop_front());
        refresh();
        if (m_done) begin
            done_cnt++;
            last_len = m_len;
            last_err = m_err;
            last_pid = m_pid;
        end
    endtask

    // Bounded wait for pkt_done plus one settling cycle back into IDLE.
    task automatic wait_done(input int target, output logic seen);
        int i;
        i = 0;
        while (done_cnt < target && i < 60) begin
            step();
            i++;
        end
        seen = (done_cnt >= target);
        step();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({ifa.r_enable, ifa.out_data, ifa.out_valid, ifa.out_first, ifa.pkt_done,
             ifa.pkt_len, ifa.pkt_err, ifa.pid_err, ifa.busy} !== 22'd0) begin
            n_bad++;
            $display("FAIL reset_a: outputs=%h want 0", {ifa.r_enable, ifa.out_data, ifa.out_valid,
                     ifa.out_first, ifa.pkt_done, ifa.pkt_len, ifa.pkt_err, ifa.pid_err, ifa.busy});
        end
        n_cmp++;
        if ({ifb.r_enable, ifb.out_data, ifb.out_valid, ifb.pkt_done, ifb.pkt_len, ifb.busy} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_b: outputs nonzero after reset");
        end
        n_rst = 1'b1;
        step();
        n_cmp++;
        if ({ifa.busy, ifb.busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_busy: busy a/b=%b%b want 00", ifa.busy, ifb.busy);
        end
    endtask

    task automatic test_normal();
        logic       seen;
        logic [7:0] exp_d [4] = '{8'hA5, 8'h11, 8'h22, 8'h33};
        clear_rec();
        out_ready = 1'b1;
        rcving    = 1'b1;
        for (int i = 0; i < 4; i++) push(exp_d[i]);
        repeat (3) step();
        rcving = 1'b0;
        wait_done(1, seen);
        n_cmp++;
        if (seen !== 1'b1) begin n_bad++; $display("FAIL normal_timeout: pkt_done not seen"); end
        n_cmp++;
        if (acc_data.size() !== 4) begin
            n_bad++; $display("FAIL normal_count: got %0d bytes want 4", acc_data.size());
        end
        for (int i = 0; i < 4 && i < acc_data.size(); i++) begin
            n_cmp++;
            if ({acc_data[i], acc_first[i]} !== {exp_d[i], (i == 0)} || acc_cyc[i] !== acc_cyc[0] + i) begin
                n_bad++;
                $display("FAIL normal_byte%0d: got %h first=%b cyc=%0d want %h first=%b cyc=%0d",
                         i, acc_data[i], acc_first[i], acc_cyc[i], exp_d[i], (i == 0), acc_cyc[0] + i);
            end
        end
        n_cmp++;
        if ({done_cnt, last_len, last_err, last_pid} !== {32'd1, 7'd4, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL normal_status: pulses=%0d len=%0d err=%b pid=%b want 1/4/0/0",
                     done_cnt, last_len, last_err, last_pid);
        end
        n_cmp++;
        if (m_busy !== 1'b0) begin n_bad++; $display("FAIL normal_idle: busy=%b want 0", m_busy); end
    endtask

    task automatic test_mid_reset();
        clear_rec();
        rcving = 1'b1;
        push(8'hA5); push(8'h11); push(8'h22);
        repeat (3) step();
        n_rst = 1'b0;
        #1;
        n_cmp++;
        if ({ifa.r_enable, ifa.out_data, ifa.out_valid, ifa.out_first, ifa.pkt_done,
             ifa.pkt_len, ifa.pkt_err, ifa.pid_err, ifa.busy} !== 22'd0) begin
            n_bad++;
            $display("FAIL midreset_outputs: outputs=%h want 0", {ifa.r_enable, ifa.out_data,
                     ifa.out_valid, ifa.out_first, ifa.pkt_done, ifa.pkt_len, ifa.pkt_err,
                     ifa.pid_err, ifa.busy});
        end
        qa.delete();
        refresh();
        rcving = 1'b0;
        #3;
        n_rst = 1'b1;
        step();
        n_cmp++;
        if ({ifa.busy, ifa.out_valid} !== 2'b00) begin
            n_bad++; $display("FAIL midreset_release: busy=%b valid=%b want 00", ifa.busy, ifa.out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic       seen;
        int         i;
        logic [7:0] exp_d [4] = '{8'hA5, 8'h11, 8'h22, 8'h33};
        clear_rec();
        out_ready = 1'b1;
        rcving    = 1'b1;
        for (int k = 0; k < 4; k++) push(exp_d[k]);
        i = 0;
        while (!(m_valid && m_data == 8'h22) && i < 20) begin step(); i++; end
        n_cmp++;
        if (i >= 20) begin n_bad++; $display("FAIL bp_reach22: byte 22 never presented"); end
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if ({m_valid, m_data, ifa.r_enable} !== {1'b1, 8'h22, 1'b0}) begin
                n_bad++;
                $display("FAIL bp_stall%0d: valid=%b data=%h r_enable=%b want 1/22/0",
                         k, m_valid, m_data, ifa.r_enable);
            end
        end
        out_ready = 1'b1;
        rcving    = 1'b0;
        wait_done(1, seen);
        n_cmp++;
        if (acc_data.size() !== 4) begin
            n_bad++; $display("FAIL bp_count: got %0d bytes want 4", acc_data.size());
        end
        for (int k = 0; k < 4 && k < acc_data.size(); k++) begin
            n_cmp++;
            if ({acc_data[k], acc_first[k]} !== {exp_d[k], (k == 0)}) begin
                n_bad++;
                $display("FAIL bp_byte%0d: got %h first=%b want %h", k, acc_data[k], acc_first[k], exp_d[k]);
            end
        end
        n_cmp++;
        if ({seen, last_len, last_err, last_pid} !== {1'b1, 7'd4, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL bp_status: seen=%b len=%0d err=%b pid=%b want 1/4/0/0", seen, last_len, last_err, last_pid);
        end
    endtask

    task automatic test_bad_pid();
        logic seen;
        clear_rec();
        push(8'hA4); push(8'h11); push(8'h22);
        rcving = 1'b0;
        wait_done(1, seen);
        n_cmp++;
        if ({seen, acc_data.size(), pops} !== {1'b1, 32'd0, 32'd3}) begin
            n_bad++;
            $display("FAIL badpid_flow: seen=%b forwarded=%0d pops=%0d want 1/0/3", seen, acc_data.size(), pops);
        end
        n_cmp++;
        if ({last_len, last_err, last_pid} !== {7'd0, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL badpid_status: len=%0d err=%b pid=%b want 0/1/1", last_len, last_err, last_pid);
        end
    endtask

    task automatic test_rx_error();
        logic seen;
        int   i;
        clear_rec();
        out_ready = 1'b1;
        rcving    = 1'b1;
        push(8'hA5); push(8'h11);
        i = 0;
        while (!(m_valid && m_data == 8'h11) && i < 20) begin step(); i++; end
        out_ready = 1'b0;
        r_error   = 1'b1;
        step();
        r_error = 1'b0;
        n_cmp++;
        if ({m_valid, m_data} !== {1'b1, 8'h11}) begin
            n_bad++; $display("FAIL rxerr_hold: valid=%b data=%h want 1/11", m_valid, m_data);
        end
        out_ready = 1'b1;
        push(8'h22); push(8'h33);
        rcving = 1'b0;
        wait_done(1, seen);
        n_cmp++;
        if ({acc_data.size(), pops, qa.size()} !== {32'd2, 32'd4, 32'd0}) begin
            n_bad++;
            $display("FAIL rxerr_flow: forwarded=%0d pops=%0d left=%0d want 2/4/0", acc_data.size(), pops, qa.size());
        end
        n_cmp++;
        if ({seen, last_len, last_err, last_pid} !== {1'b1, 7'd2, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL rxerr_status: seen=%b len=%0d err=%b pid=%b want 1/2/1/0", seen, last_len, last_err, last_pid);
        end
    endtask

    task automatic test_overrun();
        logic seen;
        clear_rec();
        rcving = 1'b1;
        push(8'hA5); push(8'h11);
        step();
        full = 1'b1;
        step();
        full   = 1'b0;
        rcving = 1'b0;
        wait_done(1, seen);
        n_cmp++;
        if ({seen, acc_data.size(), last_len, last_err, last_pid} !== {1'b1, 32'd2, 7'd2, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL overrun_status: seen=%b fwd=%0d len=%0d err=%b pid=%b want 1/2/2/1/0",
                     seen, acc_data.size(), last_len, last_err, last_pid);
        end
    endtask

    task automatic test_zero_len();
        logic seen;
        clear_rec();
        rcving = 1'b1;
        step();
        rcving = 1'b0;
        wait_done(1, seen);
        n_cmp++;
        if ({seen, acc_data.size(), last_len, last_err, last_pid} !== {1'b1, 32'd0, 7'd0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL zerolen_status: seen=%b fwd=%0d len=%0d err=%b pid=%b want 1/0/0/1/0",
                     seen, acc_data.size(), last_len, last_err, last_pid);
        end
    endtask

    task automatic test_back_to_back();
        logic       seen;
        int         i;
        logic [6:0] len1;
        logic [7:0] exp_d [5] = '{8'hC3, 8'h44, 8'h1E, 8'h55, 8'h66};
        logic       exp_f [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        clear_rec();
        out_ready = 1'b1;
        rcving    = 1'b0;
        push(8'hC3); push(8'h44);
        i = 0;
        while (done_cnt == 0 && i < 30) begin step(); i++; end
        len1 = last_len;
        push(8'h1E); push(8'h55); push(8'h66);
        wait_done(2, seen);
        n_cmp++;
        if ({seen, done_cnt, len1, last_len, last_err} !== {1'b1, 32'd2, 7'd2, 7'd3, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_status: seen=%b pulses=%0d len1=%0d len2=%0d err=%b want 1/2/2/3/0",
                     seen, done_cnt, len1, last_len, last_err);
        end
        n_cmp++;
        if (acc_data.size() !== 5) begin
            n_bad++; $display("FAIL b2b_count: got %0d bytes want 5", acc_data.size());
        end
        for (int k = 0; k < 5 && k < acc_data.size(); k++) begin
            n_cmp++;
            if ({acc_data[k], acc_first[k]} !== {exp_d[k], exp_f[k]}) begin
                n_bad++;
                $display("FAIL b2b_byte%0d: got %h first=%b want %h first=%b",
                         k, acc_data[k], acc_first[k], exp_d[k], exp_f[k]);
            end
        end
    endtask

    task automatic test_overlength();
        logic       seen;
        logic [7:0] exp_d [4] = '{8'hA5, 8'h01, 8'h02, 8'h03};
        use_b = 1'b1;
        clear_rec();
        out_ready = 1'b1;
        rcving    = 1'b0;
        push(8'hA5); push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(8'h05);
        wait_done(1, seen);
        n_cmp++;
        if ({acc_data.size(), pops, qb.size()} !== {32'd4, 32'd6, 32'd0}) begin
            n_bad++;
            $display("FAIL overlen_flow: forwarded=%0d pops=%0d left=%0d want 4/6/0", acc_data.size(), pops, qb.size());
        end
        for (int k = 0; k < 4 && k < acc_data.size(); k++) begin
            n_cmp++;
            if (acc_data[k] !== exp_d[k]) begin
                n_bad++; $display("FAIL overlen_byte%0d: got %h want %h", k, acc_data[k], exp_d[k]);
            end
        end
        n_cmp++;
        if ({seen, last_len, last_err, last_pid} !== {1'b1, 7'd4, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL overlen_status: seen=%b len=%0d err=%b pid=%b want 1/4/1/0", seen, last_len, last_err, last_pid);
        end
        use_b = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        cyc       = 0;
        pops      = 0;
        done_cnt  = 0;
        last_len  = 7'd0;
        last_err  = 1'b0;
        last_pid  = 1'b0;
        use_b     = 1'b0;
        rcving    = 1'b0;
        r_error   = 1'b0;
        full      = 1'b0;
        out_ready = 1'b1;
        refresh();
        n_rst = 1'b1;
        #2 n_rst = 1'b0;

        test_reset();
        test_normal();
        test_mid_reset();
        test_backpressure();
        test_bad_pid();
        test_rx_error();
        test_overrun();
        test_zero_len();
        test_back_to_back();
        test_overlength();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
